// File: rtl/serial_sched_pkg.sv
// Shared types and defaults for the round-robin serial adder scheduler.
package serial_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StResp
   } state_e;

   localparam int unsigned DefNReq  = 2;
   localparam int unsigned DefWidth = 8;

   // Bit counter width; a one-bit operand still needs a one-bit counter.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_sched_if.sv
// Requester, serial-core and response signals of the scheduler.
interface serial_adder_sched_if
   import serial_sched_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned ID_W  = $clog2(N_REQ)
);

   logic [N_REQ-1:0]            req_vld;
   logic [N_REQ-1:0]            req_rdy;
   logic [N_REQ-1:0][WIDTH-1:0] req_a;
   logic [N_REQ-1:0][WIDTH-1:0] req_b;
   logic                        sa_vld;
   logic                        sa_a;
   logic                        sa_b;
   logic                        sa_last;
   logic                        sa_sum;
   logic                        resp_vld;
   logic                        resp_rdy;
   logic [ID_W-1:0]             resp_id;
   logic [WIDTH-1:0]            resp_sum;

   // Scheduler side.
   modport slave (
      input  req_vld, req_a, req_b, sa_sum, resp_rdy,
      output req_rdy, sa_vld, sa_a, sa_b, sa_last, resp_vld, resp_id, resp_sum
   );

   // Clients plus the serial adder core.
   modport master (
      output req_vld, req_a, req_b, sa_sum, resp_rdy,
      input  req_rdy, sa_vld, sa_a, sa_b, sa_last, resp_vld, resp_id, resp_sum
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request after ptr_i, with wrap.
module rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  idx_o
);

   // Walk candidates ptr+1 .. ptr+N_REQ and keep the first requesting one.
   always_comb begin
      logic            found;
      int unsigned     cand;
      logic [ID_W-1:0] cand_idx;
      gnt_o    = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand     = (32'(ptr_i) + i) % N_REQ;
         cand_idx = ID_W'(cand);
         if (en_i && !found && req_i[cand_idx]) begin
            found           = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/serial_adder_sched.sv
// Shares one bit-serial adder core between N_REQ requesters, round-robin.
module serial_adder_sched
   import serial_sched_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input logic                 clk,
   input logic                 rst,
   serial_adder_sched_if.slave bus
);

   localparam int unsigned CntW = cnt_w(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [ID_W-1:0]  id_q, id_d, ptr_q, ptr_d, gnt_idx;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [N_REQ-1:0] gnt;
   logic             arb_en, gnt_any, last_bit;

   // No grant while in reset so req_rdy shows its reset value.
   assign arb_en   = (state_q == StIdle) && !rst;
   assign gnt_any  = |gnt;
   assign last_bit = (cnt_q == CntW'(WIDTH - 1));

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req_i (bus.req_vld),
      .ptr_i (ptr_q),
      .en_i  (arb_en),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state: grant -> WIDTH shift cycles -> hold response until taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (gnt_any)      state_d = StShift;
         StShift: if (last_bit)     state_d = StResp;
         StResp:  if (bus.resp_rdy) state_d = StIdle;
         default:                   state_d = StIdle;
      endcase
   end

   // Outputs decoded from state; everything idles at zero.
   always_comb begin
      bus.req_rdy  = gnt;
      bus.sa_vld   = 1'b0;
      bus.sa_a     = 1'b0;
      bus.sa_b     = 1'b0;
      bus.sa_last  = 1'b0;
      bus.resp_vld = 1'b0;
      bus.resp_id  = '0;
      bus.resp_sum = '0;
      unique case (state_q)
         StShift: begin
            bus.sa_vld  = 1'b1;
            bus.sa_a    = a_q[0];
            bus.sa_b    = b_q[0];
            bus.sa_last = last_bit;
         end
         StResp: begin
            bus.resp_vld = 1'b1;
            bus.resp_id  = id_q;
            bus.resp_sum = res_q;
         end
         default: ;
      endcase
   end

   // Datapath next-state: latch on grant, shift operands out and sum bits in.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
      id_d  = id_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if ((state_q == StIdle) && gnt_any) begin
         a_d   = bus.req_a[gnt_idx];
         b_d   = bus.req_b[gnt_idx];
         id_d  = gnt_idx;
         ptr_d = gnt_idx;
         cnt_d = '0;
      end else if (state_q == StShift) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         // After WIDTH shifts the first (LSB) sum bit has reached bit 0.
         res_d = (res_q >> 1) | (WIDTH'(bus.sa_sum) << (WIDTH - 1));
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Datapath registers; pointer resets to N_REQ-1 so requester 0 goes first.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         id_q  <= '0;
         ptr_q <= ID_W'(N_REQ - 1);
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         res_q <= res_d;
         id_q  <= id_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_serial_adder_sched.sv
// Randomised and directed bench for serial_adder_sched with a transaction-level model.
module tb_serial_adder_sched;

   localparam int unsigned N  = 2;
   localparam int unsigned W  = 8;
   localparam int unsigned IW = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_adder_sched_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus  ();
   serial_adder_sched_if #(.N_REQ(N), .WIDTH(1), .ID_W(IW)) bus1 ();

   serial_adder_sched #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   serial_adder_sched #(.N_REQ(N), .WIDTH(1), .ID_W(IW)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // Serial adder core models: full adder with carry cleared on last bit.
   logic carry_q, carry1_q;
   assign bus.sa_sum  = bus.sa_a ^ bus.sa_b ^ carry_q;
   assign bus1.sa_sum = bus1.sa_a ^ bus1.sa_b ^ carry1_q;

   always_ff @(posedge clk) begin
      if (rst) carry_q <= 1'b0;
      else if (bus.sa_vld)
         carry_q <= bus.sa_last ? 1'b0 :
                    ((bus.sa_a & bus.sa_b) | (carry_q & (bus.sa_a ^ bus.sa_b)));
   end

   always_ff @(posedge clk) begin
      if (rst) carry1_q <= 1'b0;
      else if (bus1.sa_vld)
         carry1_q <= bus1.sa_last ? 1'b0 :
                     ((bus1.sa_a & bus1.sa_b) | (carry1_q & (bus1.sa_a ^ bus1.sa_b)));
   end

   int n_cmp = 0;
   int n_err = 0;

   // Stimulus state
   logic [N-1:0] pend_vld  = '0;
   logic [W-1:0] pend_a [N];
   logic [W-1:0] pend_b [N];
   logic [N-1:0] refill    = '0;
   bit           rand_mode = 1'b0;
   logic         rdy_ctl   = 1'b1;
   logic         rst_ctl   = 1'b1;
   logic [N-1:0] w1_vld    = '0;

   // Reference model: phase 0 idle, 1 streaming bits, 2 response pending
   int           m_phase = 0;
   int           m_k     = 0;
   int           m_ptr   = N - 1;
   int           m_id    = 0;
   logic [W-1:0] m_a, m_b, m_sum;

   int           dlog[$];
   int           got_id[$];
   logic [W-1:0] got_sum[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic monitor();
      int           exp_g;
      logic [N-1:0] exp_rdy;
      if (rst) begin
         m_phase = 0;
         m_ptr   = N - 1;
         return;
      end
      for (int g = 0; g < N; g++) begin
         if (bus.req_rdy[g]) begin
            pend_vld[g] = 1'b0;
            dlog.push_back(g);
         end
      end
      exp_g   = -1;
      exp_rdy = '0;
      if (m_phase == 0) begin
         for (int i = 1; i <= N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (exp_g < 0 && bus.req_vld[j]) exp_g = j;
         end
      end
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
      check("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
      case (m_phase)
         0: begin
            check("idle_sa_vld", 32'(bus.sa_vld), 32'(0));
            check("idle_resp_vld", 32'(bus.resp_vld), 32'(0));
            if (exp_g >= 0) begin
               m_a     = bus.req_a[exp_g];
               m_b     = bus.req_b[exp_g];
               m_sum   = m_a + m_b;
               m_id    = exp_g;
               m_ptr   = exp_g;
               m_k     = 0;
               m_phase = 1;
            end
         end
         1: begin
            check("sa_vld", 32'(bus.sa_vld), 32'(1));
            check("sa_a", 32'(bus.sa_a), 32'(m_a[m_k]));
            check("sa_b", 32'(bus.sa_b), 32'(m_b[m_k]));
            check("sa_last", 32'(bus.sa_last), 32'(m_k == W - 1));
            check("shift_resp_vld", 32'(bus.resp_vld), 32'(0));
            m_k++;
            if (m_k == W) m_phase = 2;
         end
         default: begin
            check("resp_vld", 32'(bus.resp_vld), 32'(1));
            check("resp_id", 32'(bus.resp_id), 32'(m_id));
            check("resp_sum", 32'(bus.resp_sum), 32'(m_sum));
            check("resp_sa_vld", 32'(bus.sa_vld), 32'(0));
            if (bus.resp_rdy) begin
               got_sum.push_back(bus.resp_sum);
               got_id.push_back(int'(bus.resp_id));
               m_phase = 0;
            end
         end
      endcase
   endtask

   // One clock: update and drive inputs just after posedge, observe at negedge.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int g = 0; g < N; g++) begin
         if (!pend_vld[g] && (refill[g] || (rand_mode && $urandom_range(0, 2) == 0))) begin
            pend_vld[g] = 1'b1;
            pend_a[g]   = W'($urandom());
            pend_b[g]   = W'($urandom());
         end else if (pend_vld[g] && rand_mode && $urandom_range(0, 9) == 0) begin
            pend_vld[g] = 1'b0;
         end
      end
      if (rand_mode) rdy_ctl = ($urandom_range(0, 3) != 0);
      rst          = rst_ctl;
      bus.req_vld  = pend_vld;
      bus.resp_rdy = rdy_ctl;
      for (int g = 0; g < N; g++) begin
         bus.req_a[g] = pend_a[g];
         bus.req_b[g] = pend_b[g];
      end
      bus1.req_vld  = w1_vld;
      bus1.req_a[0] = 1'b1;
      bus1.req_b[0] = 1'b1;
      bus1.req_a[1] = 1'b0;
      bus1.req_b[1] = 1'b0;
      bus1.resp_rdy = 1'b1;
      @(negedge clk);
      monitor();
   endtask

   task automatic wait_resp(input int n, input int budget);
      int c;
      c = 0;
      while (got_sum.size() < n && c < budget) begin
         cycle();
         c++;
      end
      check("resp_count", 32'(got_sum.size()), 32'(n));
   endtask

   task automatic drain();
      rand_mode = 1'b0;
      refill    = '0;
      pend_vld  = '0;
      rdy_ctl   = 1'b1;
      for (int c = 0; c < 4 * W && m_phase != 0; c++) cycle();
      cycle();
   endtask

   task automatic do_reset();
      rst_ctl = 1'b1;
      cycle();
      cycle();
      rst_ctl = 1'b0;
   endtask

   initial begin
      int w1_bits, w1_resp, c;
      for (int g = 0; g < N; g++) begin
         pend_a[g] = '0;
         pend_b[g] = '0;
      end

      // Reset values
      do_reset();
      cycle();
      check("rst_req_rdy", 32'(bus.req_rdy), 32'(0));
      check("rst_sa_vld", 32'(bus.sa_vld), 32'(0));
      check("rst_sa_a", 32'(bus.sa_a), 32'(0));
      check("rst_sa_b", 32'(bus.sa_b), 32'(0));
      check("rst_sa_last", 32'(bus.sa_last), 32'(0));
      check("rst_resp_vld", 32'(bus.resp_vld), 32'(0));
      check("rst_resp_id", 32'(bus.resp_id), 32'(0));
      check("rst_resp_sum", 32'(bus.resp_sum), 32'(0));
      check("rst_w1_resp_vld", 32'(bus1.resp_vld), 32'(0));

      // Single request 5A + 33
      got_sum.delete(); got_id.delete();
      pend_a[0] = 8'h5A; pend_b[0] = 8'h33; pend_vld[0] = 1'b1;
      wait_resp(1, 30);
      if (got_sum.size() > 0) begin
         check("single_sum", 32'(got_sum[0]), 32'h8D);
         check("single_id", 32'(got_id[0]), 32'(0));
      end
      drain();

      // Overflow then reuse: carry must not leak into the next operation
      got_sum.delete(); got_id.delete();
      pend_a[0] = 8'hFF; pend_b[0] = 8'h01; pend_vld[0] = 1'b1;
      c = 0;
      while (pend_vld[0] && c < 20) begin cycle(); c++; end
      check("ovf_granted", 32'(pend_vld[0]), 32'(0));
      pend_a[0] = 8'h01; pend_b[0] = 8'h01; pend_vld[0] = 1'b1;
      wait_resp(2, 40);
      if (got_sum.size() > 1) begin
         check("ovf_sum", 32'(got_sum[0]), 32'h00);
         check("reuse_sum", 32'(got_sum[1]), 32'h02);
      end
      drain();

      // Contention: both hold requests; grants must alternate from 0
      do_reset();
      got_sum.delete(); got_id.delete(); dlog.delete();
      refill = 2'b11;
      c = 0;
      while (dlog.size() < 4 && c < 100) begin cycle(); c++; end
      refill = '0; pend_vld = '0;
      wait_resp(4, 40);
      check("cont_grants", 32'(dlog.size()), 32'(4));
      for (int i = 0; i < 4 && i < dlog.size(); i++) check("cont_order", 32'(dlog[i]), 32'(i % 2));
      for (int i = 0; i < 4 && i < got_id.size(); i++) check("cont_id", 32'(got_id[i]), 32'(i % 2));
      drain();

      // Back-pressure: 5 cycles with resp_rdy low while requester 1 waits
      got_sum.delete(); got_id.delete();
      rdy_ctl = 1'b0;
      pend_a[0] = 8'h3C; pend_b[0] = 8'hA5; pend_vld[0] = 1'b1;
      c = 0;
      while (m_phase != 2 && c < 30) begin cycle(); c++; end
      pend_a[1] = 8'h11; pend_b[1] = 8'h22; pend_vld[1] = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      check("bp_resp_vld", 32'(bus.resp_vld), 32'(1));
      check("bp_resp_sum", 32'(bus.resp_sum), 32'hE1);
      check("bp_req_rdy", 32'(bus.req_rdy), 32'(0));
      rdy_ctl = 1'b1;
      cycle();
      cycle();
      check("bp_regrant", 32'(bus.req_rdy), 32'(2));
      wait_resp(2, 30);
      drain();

      // Reset in the middle of streaming
      got_sum.delete(); got_id.delete();
      pend_a[0] = 8'hC3; pend_b[0] = 8'h5A; pend_vld[0] = 1'b1;
      c = 0;
      while (!(m_phase == 1 && m_k == 3) && c < 30) begin cycle(); c++; end
      rst_ctl = 1'b1;
      cycle();
      rst_ctl = 1'b0;
      cycle();
      check("mid_rst_sa_vld", 32'(bus.sa_vld), 32'(0));
      check("mid_rst_resp_vld", 32'(bus.resp_vld), 32'(0));
      check("mid_rst_resp_sum", 32'(bus.resp_sum), 32'(0));
      pend_a[0] = 8'h10; pend_b[0] = 8'h20; pend_vld[0] = 1'b1;
      wait_resp(1, 30);
      if (got_sum.size() > 0) begin
         check("post_rst_sum", 32'(got_sum[0]), 32'h30);
         check("post_rst_id", 32'(got_id[0]), 32'(0));
      end
      drain();
      check("post_rst_count", 32'(got_sum.size()), 32'(1));

      // Random traffic with dropped requests and random back-pressure
      rand_mode = 1'b1;
      for (int i = 0; i < 600; i++) cycle();
      drain();
      check("rand_idle", 32'(bus.resp_vld | bus.sa_vld), 32'(0));

      // One-bit build: 1 + 1 wraps to 0, single cycle with vld and last
      w1_bits = 0;
      w1_resp = 0;
      w1_vld  = 2'b01;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (bus1.req_rdy[0]) w1_vld = '0;
         if (bus1.sa_vld) begin
            w1_bits++;
            check("w1_last", 32'(bus1.sa_last), 32'(1));
         end
         if (bus1.resp_vld) begin
            w1_resp++;
            check("w1_sum", 32'(bus1.resp_sum), 32'(0));
            check("w1_id", 32'(bus1.resp_id), 32'(0));
         end
      end
      check("w1_bits", 32'(w1_bits), 32'(1));
      check("w1_resp", 32'(w1_resp), 32'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
